// File: rtl/mips_avalon_arbiter_if.sv
// Avalon memory-port bundle shared by the arbiter (master) and the memory/bus model (slave).
interface mips_avalon_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   mem_address;
  logic            mem_read;
  logic            mem_write;
  logic [DW-1:0]   mem_writedata;
  logic [DW/8-1:0] mem_byteenable;
  logic            waitrequest;
  logic [DW-1:0]   mem_readdata;

  modport master (
    output mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
    input  waitrequest, mem_readdata
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
    output waitrequest, mem_readdata
  );
endinterface

// File: rtl/mips_avalon_arbiter.sv
// Shares one Avalon port between I-fill, D-fill and write-buffer drain, one transaction at a time.
// Define MIPS_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed instr > data > write.
module mips_avalon_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [AW-1:0]        i_addr,
  output logic                 i_done,
  output logic [DW-1:0]        i_rdata,
  input  logic                 d_req,
  input  logic [AW-1:0]        d_addr,
  output logic                 d_done,
  output logic [DW-1:0]        d_rdata,
  input  logic                 w_req,
  input  logic [AW-1:0]        w_addr,
  input  logic [DW-1:0]        w_wdata,
  input  logic [DW/8-1:0]      w_be,
  output logic                 w_done,
  mips_avalon_arbiter_if.master bus,
  output logic                 busy,
  output logic [1:0]           owner
);
  localparam int BW = DW / 8;
  localparam logic [1:0] OWN_I    = 2'd0;
  localparam logic [1:0] OWN_D    = 2'd1;
  localparam logic [1:0] OWN_W    = 2'd2;
  localparam logic [1:0] OWN_NONE = 2'd3;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [BW-1:0] be_q, be_d;
  logic          rd_q, rd_d, wr_q, wr_d, busy_q, busy_d;
  logic          i_done_q, i_done_d, d_done_q, d_done_d, w_done_q, w_done_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic [2:0]    req;
  logic [1:0]    gnt;

  assign req = {w_req, d_req, i_req};

`ifdef MIPS_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;

  // Walk backwards so the first requester found from the pointer wins.
  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] sel;
    int         idx;
    sel = OWN_NONE;
    for (int k = 2; k >= 0; k--) begin
      idx = (int'(p) + k) % 3;
      if (r[idx]) sel = 2'(idx);
    end
    return sel;
  endfunction

  assign gnt = pick(req, ptr_q);
`else
  function automatic logic [1:0] pick(input logic [2:0] r);
    if (r[0]) return OWN_I;
    if (r[1]) return OWN_D;
    if (r[2]) return OWN_W;
    return OWN_NONE;
  endfunction

  assign gnt = pick(req);
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    busy_d    = busy_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    w_done_d  = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt != OWN_NONE) begin
          owner_d = gnt;
          busy_d  = 1'b1;
          state_d = BUSY;
          if (gnt == OWN_W) begin
            addr_d  = w_addr;
            wdata_d = w_wdata;
            be_d    = w_be;
            wr_d    = 1'b1;
          end else begin
            addr_d  = (gnt == OWN_I) ? i_addr : d_addr;
            be_d    = '1;
            rd_d    = 1'b1;
          end
        end
      end
      BUSY: begin
        if (!bus.waitrequest) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = DONE;
          case (owner_q)
            OWN_I: begin i_done_d = 1'b1; i_rdata_d = bus.mem_readdata; end
            OWN_D: begin d_done_d = 1'b1; d_rdata_d = bus.mem_readdata; end
            OWN_W: w_done_d = 1'b1;
            default: ;
          endcase
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
        ptr_d   = (owner_q == OWN_W) ? OWN_I : owner_q + 2'd1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      w_done_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
      ptr_q     <= OWN_I;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      w_done_q  <= w_done_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign bus.mem_address    = addr_q;
  assign bus.mem_read       = rd_q;
  assign bus.mem_write      = wr_q;
  assign bus.mem_writedata  = wdata_q;
  assign bus.mem_byteenable = be_q;
  assign i_done             = i_done_q;
  assign d_done             = d_done_q;
  assign w_done             = w_done_q;
  assign i_rdata            = i_rdata_q;
  assign d_rdata            = d_rdata_q;
  assign busy               = busy_q;
  assign owner              = owner_q;
endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Randomized bench for mips_avalon_arbiter: transaction-level reference model, per-cycle compare, directed scenarios.
module tb_mips_avalon_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          i_req = 1'b0, d_req = 1'b0, w_req = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0, w_addr = '0;
  logic [DW-1:0] w_wdata = '0;
  logic [BW-1:0] w_be = '0;
  logic          i_done, d_done, w_done, busy;
  logic [DW-1:0] i_rdata, d_rdata;
  logic [1:0]    owner;

  mips_avalon_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mips_avalon_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_done(d_done), .d_rdata(d_rdata),
    .w_req(w_req), .w_addr(w_addr), .w_wdata(w_wdata), .w_be(w_be), .w_done(w_done),
    .bus(bus), .busy(busy), .owner(owner)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: one transaction in flight ----------------
  int            m_phase = 0;  // 0 free, 1 on the bus, 2 completion cycle
  int            m_owner = 3;
  int            m_ptr   = 0;
  int            m_pick;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [BW-1:0] m_be    = '0;
  logic          m_rd = 1'b0, m_wr = 1'b0, m_busy = 1'b0;
  logic [2:0]    m_done  = 3'b000;
  logic [DW-1:0] m_ri = '0, m_rdd = '0;

  function automatic int model_pick(input logic [2:0] r, input int start);
    for (int k = 0; k < 3; k++)
      if (r[(start + k) % 3]) return (start + k) % 3;
    return 3;
  endfunction

`ifdef MIPS_ARB_ROUND_ROBIN_EN
  always_comb m_pick = model_pick({w_req, d_req, i_req}, m_ptr);
`else
  always_comb m_pick = model_pick({w_req, d_req, i_req}, 0);
`endif

  always @(posedge clk) begin
    m_done <= 3'b000;
    if (rst) begin
      m_phase <= 0; m_owner <= 3; m_ptr <= 0;
      m_addr <= '0; m_wdata <= '0; m_be <= '0;
      m_rd <= 1'b0; m_wr <= 1'b0; m_busy <= 1'b0;
      m_ri <= '0; m_rdd <= '0;
    end else if (m_phase == 0) begin
      if (m_pick != 3) begin
        m_phase <= 1; m_busy <= 1'b1; m_owner <= m_pick;
        if (m_pick == 2) begin
          m_addr <= w_addr; m_wdata <= w_wdata; m_be <= w_be; m_wr <= 1'b1;
        end else begin
          m_addr <= (m_pick == 0) ? i_addr : d_addr; m_be <= '1; m_rd <= 1'b1;
        end
      end
    end else if (m_phase == 1) begin
      if (!bus.waitrequest) begin
        m_phase <= 2; m_rd <= 1'b0; m_wr <= 1'b0;
        m_done[m_owner] <= 1'b1;
        if (m_owner == 0) m_ri  <= bus.mem_readdata;
        if (m_owner == 1) m_rdd <= bus.mem_readdata;
      end
    end else begin
      m_phase <= 0; m_busy <= 1'b0; m_ptr <= (m_owner + 1) % 3;
    end
  end

  always @(negedge clk) begin
    check("busy",    32'(busy),               32'(m_busy));
    check("owner",   32'(owner),              32'(m_owner));
    check("read",    32'(bus.mem_read),       32'(m_rd));
    check("write",   32'(bus.mem_write),      32'(m_wr));
    check("address", bus.mem_address,         m_addr);
    check("be",      32'(bus.mem_byteenable), 32'(m_be));
    if (m_wr) check("wdata", bus.mem_writedata, m_wdata);
    check("dones",   32'({w_done, d_done, i_done}), 32'(m_done));
    check("i_rdata", i_rdata, m_ri);
    check("d_rdata", d_rdata, m_rdd);
  end

  // ---------------- random requesters ----------------
  task automatic agent_step();
    bus.waitrequest  = ($urandom_range(0, 1) == 1);
    bus.mem_readdata = $urandom;
    rst = ($urandom_range(0, 299) == 0);
    if (i_done) begin
      if ($urandom_range(0, 1) == 0) i_req = 1'b0; else i_addr = $urandom;
    end else if (!i_req && $urandom_range(0, 3) == 0) begin
      i_req = 1'b1; i_addr = $urandom;
    end
    if (d_done) begin
      if ($urandom_range(0, 1) == 0) d_req = 1'b0; else d_addr = $urandom;
    end else if (!d_req && $urandom_range(0, 3) == 0) begin
      d_req = 1'b1; d_addr = $urandom;
    end
    if (w_done) begin
      if ($urandom_range(0, 1) == 0) w_req = 1'b0;
      else begin w_addr = $urandom; w_wdata = $urandom; w_be = 4'($urandom); end
    end else if (!w_req && $urandom_range(0, 3) == 0) begin
      w_req = 1'b1; w_addr = $urandom; w_wdata = $urandom; w_be = 4'($urandom);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int order[4];
  int got;
  int w_at;

  initial begin
    bus.waitrequest  = 1'b1;
    bus.mem_readdata = '0;
    repeat (2) @(negedge clk);
    check("rst_owner", 32'(owner), 32'd3);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_read",  32'(bus.mem_read), 32'd0);
    check("rst_be",    32'(bus.mem_byteenable), 32'd0);
    check("rst_wdata", bus.mem_writedata, 32'd0);
    check("rst_irdata", i_rdata, 32'd0);
    rst = 1'b0;

    // single instruction read with four strobe cycles
    i_req = 1'b1; i_addr = 32'h1000; bus.waitrequest = 1'b1; bus.mem_readdata = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t1_read", 32'(bus.mem_read), 32'd1);
      check("t1_addr", bus.mem_address, 32'h1000);
      check("t1_nodone", 32'(i_done), 32'd0);
      if (k == 3) bus.waitrequest = 1'b0;
    end
    @(negedge clk);
    check("t1_done", 32'(i_done), 32'd1);
    check("t1_rdata", i_rdata, 32'hDEADBEEF);
    check("t1_strobe_drop", 32'(bus.mem_read), 32'd0);
    i_req = 1'b0;
    @(negedge clk);
    check("t1_done_once", 32'(i_done), 32'd0);
    @(negedge clk);

    // zero-wait write must not touch read data
    w_req = 1'b1; w_addr = 32'h2004; w_wdata = 32'h12345678; w_be = 4'b0011;
    bus.mem_readdata = 32'h00000055;
    @(negedge clk);
    check("t2_write", 32'(bus.mem_write), 32'd1);
    check("t2_read0", 32'(bus.mem_read), 32'd0);
    check("t2_addr", bus.mem_address, 32'h2004);
    check("t2_wdata", bus.mem_writedata, 32'h12345678);
    check("t2_be", 32'(bus.mem_byteenable), 32'h3);
    @(negedge clk);
    check("t2_done", 32'(w_done), 32'd1);
    check("t2_irdata", i_rdata, 32'hDEADBEEF);
    check("t2_drdata", d_rdata, 32'd0);
    w_req = 1'b0;
    repeat (2) @(negedge clk);

    // data requester drops req mid-transaction
    d_req = 1'b1; d_addr = 32'h3000; bus.waitrequest = 1'b1; bus.mem_readdata = 32'hCAFEF00D;
    @(negedge clk);
    check("t6_owner", 32'(owner), 32'd1);
    d_req = 1'b0;
    @(negedge clk);
    bus.waitrequest = 1'b0;
    @(negedge clk);
    check("t6_done", 32'(d_done), 32'd1);
    check("t6_rdata", d_rdata, 32'hCAFEF00D);
    @(negedge clk);
    @(negedge clk);
    check("t6_nogrant", 32'(busy), 32'd0);

    // reset while stalled
    i_req = 1'b1; i_addr = 32'h40; bus.waitrequest = 1'b1;
    @(negedge clk);
    check("t5_busy", 32'(busy), 32'd1);
    rst = 1'b1; i_req = 1'b0;
    @(negedge clk);
    check("t5_read", 32'(bus.mem_read), 32'd0);
    check("t5_busy0", 32'(busy), 32'd0);
    check("t5_owner", 32'(owner), 32'd3);
    check("t5_nodone", 32'(i_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_nodone2", 32'(i_done), 32'd0);

    // all three at once, then all three again after the write completes
    pulse_reset();
    i_req = 1'b1; d_req = 1'b1; w_req = 1'b1; bus.waitrequest = 1'b0;
    i_addr = 32'h100; d_addr = 32'h200; w_addr = 32'h300;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (i_done) begin order[got] = 0; got++; i_req = 1'b0; end
      if (d_done) begin order[got] = 1; got++; d_req = 1'b0; end
      if (w_done) begin order[got] = 2; got++; w_req = 1'b0; end
      if (got == 3 && w_done) begin i_req = 1'b1; d_req = 1'b1; w_req = 1'b1; end
    end
    i_req = 1'b0; d_req = 1'b0; w_req = 1'b0;
    check("t3_count", 32'(got), 32'd4);
    for (int k = 0; k < got; k++) check("t3_order", 32'(order[k]), (k == 3) ? 32'd0 : 32'(k));
    repeat (6) @(negedge clk);

    // instruction re-requests every time; write must not starve under round-robin
    pulse_reset();
    i_req = 1'b1; w_req = 1'b1; bus.waitrequest = 1'b0;
    got = 0; w_at = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (i_done) got++;
      if (w_done) begin got++; if (w_at == 0) w_at = got; end
    end
    i_req = 1'b0; w_req = 1'b0;
    check("t4_count", 32'(got), 32'd4);
`ifdef MIPS_ARB_ROUND_ROBIN_EN
    check("t4_write_slot", 32'(w_at), 32'd2);
`else
    check("t4_write_starved", 32'(w_at), 32'd0);
`endif
    repeat (6) @(negedge clk);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      agent_step();
    end
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; w_req = 1'b0; bus.waitrequest = 1'b0;
    repeat (10) @(negedge clk);
    check("end_idle", 32'(busy), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
